// File: rtl/c499_lock_pkg.sv
// Shared constants and types for the c499 key-delivery stage.
// Frame = KEY_W key bits (p1..p4, X_1..X_3, MSB first) followed by a CRC-8 tag.
package c499_lock_pkg;

  localparam int KEY_W = 7;
  localparam int CHK_W = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CHECK   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int P1_IDX = 6;
  localparam int P2_IDX = 5;
  localparam int P3_IDX = 4;
  localparam int P4_IDX = 3;
  localparam int X1_IDX = 2;
  localparam int X2_IDX = 1;
  localparam int X3_IDX = 0;

endpackage

// File: rtl/c499_crc8_serial.sv
// Bit-serial CRC-8 (MSB first, no reflection); updates one bit per cycle when en is high.
// clr takes priority over en and returns the register to CRC8_INIT.
module c499_crc8_serial
  import c499_lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/c499_key_loader.sv
// Receives a serial key+CRC frame, verifies it and drives the c499 lock keys from registers.
// Results appear two cycles after the last bit; key_ready drops during CHECK and forever after lockout.
module c499_key_loader
  import c499_lock_pkg::*;
#(
  parameter int MAX_FAIL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic key_sdi,
  input  logic key_valid,
  output logic key_ready,
  input  logic key_abort,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic X_1,
  output logic X_2,
  output logic X_3,
  output logic key_loaded,
  output logic frame_err,
  output logic locked_out
);

  localparam logic [3:0] KEY_LEN  = 4'(KEY_W);
  localparam logic [3:0] LAST_BIT = 4'(KEY_W + CHK_W - 1);
  localparam logic [3:0] FAIL_LIM = 4'(MAX_FAIL);

  state_t             state;
  logic [3:0]         bit_cnt;
  logic [3:0]         fail_cnt;
  logic [3:0]         fail_nxt;
  logic [KEY_W-1:0]   shreg;
  logic [KEY_W-1:0]   key_q;
  logic [CHK_W-1:0]   tag;
  logic [7:0]         crc;
  logic               take_abort;
  logic               take_bit;
  logic               crc_en;
  logic               crc_clr;

  assign key_ready  = (state == IDLE) || (state == SHIFT);
  // Abort beats a simultaneous valid bit, so the bit is never consumed.
  assign take_abort = key_ready & key_abort;
  assign take_bit   = key_ready & key_valid & ~key_abort;
  assign crc_en     = take_bit & (bit_cnt < KEY_LEN);
  assign crc_clr    = take_abort | (state == CHECK);
  assign fail_nxt   = fail_cnt + 4'd1;

  c499_crc8_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (key_sdi),
    .crc (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      fail_cnt   <= 4'd0;
      shreg      <= '0;
      tag        <= '0;
      key_q      <= '0;
      key_loaded <= 1'b0;
      frame_err  <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE, SHIFT: begin
          if (take_abort) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
          end else if (take_bit) begin
            if (bit_cnt < KEY_LEN) shreg <= {shreg[KEY_W-2:0], key_sdi};
            else                   tag   <= {tag[CHK_W-2:0], key_sdi};
            if (bit_cnt == LAST_BIT) begin
              state   <= CHECK;
              bit_cnt <= 4'd0;
            end else begin
              state   <= SHIFT;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        CHECK: begin
          if (crc == tag) begin
            key_q      <= shreg;
            key_loaded <= 1'b1;
            fail_cnt   <= 4'd0;
            state      <= IDLE;
          end else begin
            key_q      <= '0;
            key_loaded <= 1'b0;
            frame_err  <= 1'b1;
            fail_cnt   <= fail_nxt;
            if (fail_nxt == FAIL_LIM) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        LOCKOUT: locked_out <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  assign p1  = key_q[P1_IDX];
  assign p2  = key_q[P2_IDX];
  assign p3  = key_q[P3_IDX];
  assign p4  = key_q[P4_IDX];
  assign X_1 = key_q[X1_IDX];
  assign X_2 = key_q[X2_IDX];
  assign X_3 = key_q[X3_IDX];

endmodule

// File: tb/tb_c499_key_loader.sv
// Randomised self-checking bench for c499_key_loader against a frame-level reference model.
module tb_c499_key_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_sdi = 1'b0;
  logic key_valid = 1'b0;
  logic key_abort = 1'b0;
  logic key_ready, key_loaded, frame_err, locked_out;
  logic p1, p2, p3, p4, X_1, X_2, X_3;
  logic [6:0] dut_key;

  int total = 0;
  int bad = 0;

  logic [6:0] mk;
  logic       ml, mlock, merr;
  int         mf;

  logic [6:0] obs_key;
  logic       obs_ld, obs_err, obs_err2, obs_lock, obs_rdy, obs_rdy_chk;

  localparam logic [6:0] GOOD_KEY = 7'b1010011;
  localparam logic [7:0] GOOD_TAG = 8'hBE;
  localparam logic [7:0] BAD_TAG  = 8'hBF;

  always #5 clk = ~clk;

  assign dut_key = {p1, p2, p3, p4, X_1, X_2, X_3};

  c499_key_loader dut (
    .clk(clk), .rst(rst), .key_sdi(key_sdi), .key_valid(key_valid), .key_ready(key_ready),
    .key_abort(key_abort), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .X_1(X_1), .X_2(X_2), .X_3(X_3),
    .key_loaded(key_loaded), .frame_err(frame_err), .locked_out(locked_out)
  );

  // Reference CRC as the remainder of key(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [6:0] k);
    logic [14:0] r;
    r = {k, 8'h00};
    for (int i = 14; i >= 8; i--)
      if (r[i]) r = r ^ (15'h107 << (i - 8));
    return r[7:0];
  endfunction

  task automatic model_reset();
    mk = '0; ml = 1'b0; mlock = 1'b0; merr = 1'b0; mf = 0;
  endtask

  task automatic model_frame(input logic [6:0] k, input logic [7:0] t);
    merr = 1'b0;
    if (mlock) return;
    if (crc_ref(k) == t) begin
      mk = k; ml = 1'b1; mf = 0;
    end else begin
      mk = '0; ml = 1'b0; merr = 1'b1; mf++;
      if (mf >= 3) mlock = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    key_valid = 1'b0; key_abort = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive_bit(input logic b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        key_valid = 1'b0;
      end
    end
    @(negedge clk);
    key_valid = 1'b1;
    key_sdi   = b;
  endtask

  // Sends a whole frame, then samples the CHECK cycle, the result cycle and the cycle after.
  task automatic run_frame(input logic [6:0] k, input logic [7:0] t, input bit gaps);
    logic [14:0] f;
    f = {k, t};
    for (int i = 14; i >= 0; i--) drive_bit(f[i], gaps);
    @(negedge clk);
    key_valid   = 1'b0;
    obs_rdy_chk = key_ready;
    model_frame(k, t);
    @(negedge clk);
    obs_key = dut_key; obs_ld = key_loaded; obs_err = frame_err;
    obs_lock = locked_out; obs_rdy = key_ready;
    @(negedge clk);
    obs_err2 = frame_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    if ({dut_key, key_loaded, frame_err, locked_out, key_ready} !== {7'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_state: got %b want %b",
        {dut_key, key_loaded, frame_err, locked_out, key_ready}, {7'd0, 4'b0001});
    end
    total++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_good_frame();
    run_frame(GOOD_KEY, GOOD_TAG, 1'b0);
    if (obs_key !== GOOD_KEY || obs_ld !== 1'b1 || obs_err !== 1'b0) begin
      bad++; $display("FAIL good_frame: key=%b ld=%b err=%b want key=%b ld=1 err=0",
        obs_key, obs_ld, obs_err, GOOD_KEY);
    end
    total++;
    if (obs_rdy_chk !== 1'b0) begin
      bad++; $display("FAIL ready_in_check: got %b want 0", obs_rdy_chk);
    end
    total++;
    run_frame(7'd0, 8'h00, 1'b1);
    if (obs_key !== 7'd0 || obs_ld !== 1'b1 || obs_err !== 1'b0) begin
      bad++; $display("FAIL zero_frame: key=%b ld=%b err=%b want key=0 ld=1 err=0",
        obs_key, obs_ld, obs_err);
    end
    total++;
  endtask

  task automatic test_bad_tag();
    do_reset();
    run_frame(GOOD_KEY, GOOD_TAG, 1'b0);
    run_frame(GOOD_KEY, BAD_TAG, 1'b0);
    if ({obs_key, obs_ld, obs_err, obs_err2, obs_lock} !== {7'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL bad_tag: got key=%b ld=%b err=%b err_next=%b lock=%b want 0,0,1,0,0",
        obs_key, obs_ld, obs_err, obs_err2, obs_lock);
    end
    total++;
    if (mf != 1) begin
      bad++; $display("FAIL bad_tag_count: model fail count %0d want 1", mf);
    end
    total++;
  endtask

  task automatic test_lockout();
    do_reset();
    for (int i = 0; i < 3; i++) run_frame(GOOD_KEY, BAD_TAG, 1'b1);
    if (obs_lock !== 1'b1 || obs_rdy !== 1'b0) begin
      bad++; $display("FAIL lockout_enter: lock=%b rdy=%b want lock=1 rdy=0", obs_lock, obs_rdy);
    end
    total++;
    run_frame(GOOD_KEY, GOOD_TAG, 1'b0);
    if ({obs_key, obs_ld, obs_lock, obs_err} !== {mk, ml, mlock, merr} || obs_ld !== 1'b0) begin
      bad++; $display("FAIL lockout_ignores: key=%b ld=%b lock=%b err=%b want key=0 ld=0 lock=1 err=0",
        obs_key, obs_ld, obs_lock, obs_err);
    end
    total++;
    do_reset();
    #1;
    if (locked_out !== 1'b0 || key_ready !== 1'b1) begin
      bad++; $display("FAIL lockout_clear: lock=%b rdy=%b want lock=0 rdy=1", locked_out, key_ready);
    end
    total++;
  endtask

  task automatic test_recovery();
    do_reset();
    run_frame(GOOD_KEY, BAD_TAG, 1'b0);
    run_frame(GOOD_KEY, 8'h3E, 1'b0);
    run_frame(GOOD_KEY, GOOD_TAG, 1'b0);
    if (obs_key !== GOOD_KEY || obs_ld !== 1'b1) begin
      bad++; $display("FAIL recovery_load: key=%b ld=%b want %b ld=1", obs_key, obs_ld, GOOD_KEY);
    end
    total++;
    run_frame(GOOD_KEY, BAD_TAG, 1'b0);
    run_frame(GOOD_KEY, BAD_TAG, 1'b0);
    if ({obs_key, obs_ld, obs_lock, obs_rdy} !== {7'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL recovery_nolock: key=%b ld=%b lock=%b rdy=%b want 0,0,0,1",
        obs_key, obs_ld, obs_lock, obs_rdy);
    end
    total++;
  endtask

  task automatic test_abort();
    logic [6:0]  k2;
    logic [14:0] f;
    do_reset();
    run_frame(GOOD_KEY, GOOD_TAG, 1'b0);
    k2 = 7'b0110101;
    f  = {k2, crc_ref(k2)};
    for (int i = 14; i > 5; i--) drive_bit(f[i], 1'b0);
    @(negedge clk);
    key_abort = 1'b1; key_valid = 1'b1; key_sdi = 1'b1;
    @(negedge clk);
    key_abort = 1'b0; key_valid = 1'b0;
    if (key_ready !== 1'b1 || dut_key !== GOOD_KEY || key_loaded !== 1'b1 || frame_err !== 1'b0) begin
      bad++; $display("FAIL abort_hold: rdy=%b key=%b ld=%b err=%b want rdy=1 key=%b ld=1 err=0",
        key_ready, dut_key, key_loaded, frame_err, GOOD_KEY);
    end
    total++;
    run_frame(k2, crc_ref(k2), 1'b1);
    if (obs_key !== k2 || obs_ld !== 1'b1 || obs_err !== 1'b0) begin
      bad++; $display("FAIL abort_reload: key=%b ld=%b err=%b want key=%b ld=1 err=0",
        obs_key, obs_ld, obs_err, k2);
    end
    total++;
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    run_frame(GOOD_KEY, GOOD_TAG, 1'b0);
    for (int i = 14; i > 9; i--) drive_bit(GOOD_KEY[i - 8], 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    rst = 1'b1;
    #1;
    if ({dut_key, key_loaded, locked_out, key_ready} !== {7'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL async_reset: key=%b ld=%b lock=%b rdy=%b want 0,0,0,1",
        dut_key, key_loaded, locked_out, key_ready);
    end
    total++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frame(GOOD_KEY, GOOD_TAG, 1'b0);
    if (obs_key !== GOOD_KEY || obs_ld !== 1'b1) begin
      bad++; $display("FAIL reset_restart: key=%b ld=%b want %b ld=1", obs_key, obs_ld, GOOD_KEY);
    end
    total++;
  endtask

  task automatic test_random();
    logic [6:0] k;
    logic [7:0] t;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      k = 7'($urandom);
      t = crc_ref(k);
      if ($urandom_range(0, 2) == 0) t = t ^ 8'($urandom_range(1, 255));
      run_frame(k, t, 1'b1);
      if ({obs_key, obs_ld, obs_err, obs_lock, obs_rdy, obs_err2} !== {mk, ml, merr, mlock, ~mlock, 1'b0}) begin
        bad++; $display("FAIL random_frame%0d: got key=%b ld=%b err=%b lock=%b rdy=%b err_next=%b want key=%b ld=%b err=%b lock=%b",
          n, obs_key, obs_ld, obs_err, obs_lock, obs_rdy, obs_err2, mk, ml, merr, mlock);
      end
      total++;
      if (mlock) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_bad_tag();
    test_lockout();
    test_recovery();
    test_abort();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
